down_counter_timer: RTL and testbench

- Loadable down-counting timer: the counterpart to the free-running 4-bit up counter.
- Software or an FSM loads a start value, then starts the timer. It counts down once per clock, and a one-cycle done pulse fires when it reaches zero.
- Used as a delay/timeout generator next to the up counters in the building-blocks library.

---
 rtl/down_counter_timer.sv | 99 +++++++++
 tb/tb_down_counter_timer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with a one-cycle done pulse when the count reaches zero.
// Optional macro DOWN_COUNTER_TIMER_AUTO_RELOAD_EN turns the one-shot into a periodic timer that reloads on expiry.
// Latency: count steps one edge after start is seen, and done is registered. No backpressure: load/start/pause are sampled every edge.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;
    logic             w_at_one;

    assign w_at_one = (r_count == WIDTH'(1));

    // Timer FSM: load has top priority and always returns to IDLE; done defaults low so it can only pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_count  <= load_val;
                r_reload <= load_val;
                r_state  <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            if (r_count != '0) begin
                                r_state <= RUN;
                            end else begin
                                // Starting an already-expired timer reports expiry immediately.
                                r_done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            r_state <= PAUSE;
                        end else if (r_count == '0) begin
                            // Unreachable in normal use; recover rather than wrap below zero.
                            r_state <= IDLE;
                        end else if (w_at_one) begin
                            r_done <= 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                            r_count <= r_reload;
`else
                            r_count <= '0;
                            r_state <= IDLE;
`endif
                        end else begin
                            r_count <= r_count - WIDTH'(1);
                        end
                    end
                    PAUSE: begin
                        // Resuming costs one edge: the count is held on the edge that leaves PAUSE.
                        if (!pause) begin
                            r_state <= RUN;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // The reload value is still captured on load but nothing consumes it in one-shot mode.
    logic w_unused_reload;
    assign w_unused_reload = ^r_reload;
`endif

    assign count = r_count;
    assign done  = r_done;
    assign busy  = (r_state == RUN) || (r_state == PAUSE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: reset, countdown, pause, priority, max value, auto-reload.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Build with DOWN_COUNTER_TIMER_AUTO_RELOAD_EN defined to exercise the periodic mode.
module tb_down_counter_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    int n_checks;
    int n_errors;

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    // Sample start on the next edge.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        load     = 1'b0;
        load_val = '0;
        start    = 1'b0;
        pause    = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_count", count, 0);

        // Test 1: asynchronous reset in the middle of a run.
        do_load(4'd9);
        do_start();
        chk("t1_busy_run", busy, 1);
        step();
        step();
        step();
        chk("t1_count_pre", count, 6);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_async_count", count, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_done", done, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t1_post_done", done, 0);
            chk("t1_post_count", count, 0);
        end

`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        // Test 2: load 5, start at edge k; count 4..0 after edges k+1..k+5, done only after k+5.
        do_load(4'd5);
        chk("t2_loaded", count, 5);
        do_start();
        chk("t2_k_count", count, 5);
        chk("t2_k_busy", busy, 1);
        chk("t2_k_done", done, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t2_count", count, 5 - i);
            chk("t2_done", done, (i == 5) ? 1 : 0);
            chk("t2_busy", busy, (i == 5) ? 0 : 1);
        end
        step();
        chk("t2_done_fall", done, 0);
        chk("t2_count_hold", count, 0);

        // Test 3: load 6, start, pause for three edges once count reaches 3.
        begin
            logic [3:0] exp_cnt [10];
            logic       pz      [10];
            exp_cnt = '{4'd5, 4'd4, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
            pz      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            do_load(4'd6);
            do_start();
            for (int i = 0; i < 10; i++) begin
                pause = pz[i];
                step();
                chk("t3_count", count, exp_cnt[i]);
                chk("t3_done", done, (i == 9) ? 1 : 0);
                chk("t3_busy", busy, (i == 9) ? 0 : 1);
            end
            pause = 1'b0;
            step();
            chk("t3_done_once", done, 0);
        end
`endif

        // Test 4a: load with start in the same cycle stays IDLE.
        load     = 1'b1;
        load_val = 4'd4;
        start    = 1'b1;
        step();
        load  = 1'b0;
        start = 1'b0;
        chk("t4a_count", count, 4);
        chk("t4a_busy", busy, 0);
        step();
        chk("t4a_count_hold", count, 4);
        chk("t4a_busy_hold", busy, 0);

        // Test 4b: start with count 0 gives a single done, no busy.
        do_load(4'd0);
        do_start();
        chk("t4b_done", done, 1);
        chk("t4b_busy", busy, 0);
        step();
        chk("t4b_done_fall", done, 0);
        chk("t4b_busy_after", busy, 0);

        // Test 4c: load 7 while running at count 2 aborts with no done.
        do_load(4'd4);
        do_start();
        step();
        step();
        chk("t4c_at2", count, 2);
        do_load(4'd7);
        chk("t4c_count", count, 7);
        chk("t4c_busy", busy, 0);
        chk("t4c_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4c_no_done", done, 0);
            chk("t4c_hold", count, 7);
        end

`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        // Test 5: maximum period, done exactly 15 edges after start, no wrap.
        do_load(4'd15);
        do_start();
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t5_count", count, 15 - i);
            chk("t5_done", done, (i == 15) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_wrap", count, 0);
            chk("t5_done_low", done, 0);
            chk("t5_idle", busy, 0);
        end
`else
        // Test 6a: periodic mode, load 3 -> 2,1,3,2,1,3 with done on each reload.
        begin
            logic [3:0] exp_cnt [6];
            exp_cnt = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
            do_load(4'd3);
            do_start();
            for (int i = 0; i < 6; i++) begin
                step();
                chk("t6a_count", count, exp_cnt[i]);
                chk("t6a_done", done, (i == 2 || i == 5) ? 1 : 0);
                chk("t6a_busy", busy, 1);
            end
            // Pause still freezes the periodic counter.
            pause = 1'b1;
            step();
            pause = 1'b0;
            chk("t6a_pause", count, 3);
            step();
            chk("t6a_resume_hold", count, 3);
            step();
            chk("t6a_resume", count, 2);
        end

        // Test 6b: reload value 1 holds done high every cycle.
        do_load(4'd1);
        do_start();
        chk("t6b_start_count", count, 1);
        chk("t6b_start_done", done, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6b_done", done, 1);
            chk("t6b_count", count, 1);
            chk("t6b_busy", busy, 1);
        end
        do_load(4'd0);
        chk("t6b_stop_busy", busy, 0);
        chk("t6b_stop_done", done, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
